// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory fetch responder with wait states and preload port
// Optional: define IMEM_FETCH_CNT_EN to add the fetch_count output.
module imem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] HALT_WORD   = 32'hFFFFFFFF,
    parameter logic [31:0] BASE_ADDR   = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
`ifdef IMEM_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        req_ready_n, rsp_valid_n, rsp_err_n;
    logic [31:0] rsp_data_n;
    logic [31:0] rd_word;
    logic [31:0] mem [DEPTH];

    // Addresses below BASE_ADDR are rejected before the subtraction can wrap.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (((a - BASE_ADDR) >> 2) >= DEPTH_W);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en && !addr_bad(wr_addr)) begin
            mem[addr_idx(wr_addr)] <= wr_data;
        end
    end

    assign rd_word = mem[addr_idx(req_addr)];

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rsp_err_n   = addr_bad(req_addr);
                    rsp_data_n  = addr_bad(req_addr) ? HALT_WORD : rd_word;
                    req_ready_n = 1'b0;
                    cnt_n       = WAIT_INIT;
                    state_n     = WAIT;
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            // One WAIT edge per count plus the terminal edge gives WAIT_CYCLES + 1 latency.
            WAIT: begin
                if (cnt == 4'd0) begin
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
        end
    end

`ifdef IMEM_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'd0;
        end else if (rsp_valid && rsp_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder against an array model
// Optional: define IMEM_FETCH_CNT_EN to also check fetch_count.
module tb_imem_responder;

    localparam int          DEPTH       = 256;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] HALT_WORD   = 32'hFFFFFFFF;
    localparam logic [31:0] BASE_ADDR   = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    always #5 clk = ~clk;

    imem_responder #(
        .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .HALT_WORD(HALT_WORD), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_FETCH_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ref_cnt  = 0;
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE_ADDR) && ((a - BASE_ADDR) / 4 < DEPTH);
    endfunction

    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        if (!legal(a)) return {1'b1, HALT_WORD};
        return {1'b0, ref_mem[(a - BASE_ADDR) / 4]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        if (legal(a)) ref_mem[(a - BASE_ADDR) / 4] = d;
    endtask

    function automatic logic [31:0] gen_addr();
        case ($urandom_range(0, 3))
            0, 1:    return BASE_ADDR + 4 * $urandom_range(0, DEPTH - 1);
            2:       return BASE_ADDR + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            default: return ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFC
                            : BASE_ADDR + 4 * DEPTH + 4 * $urandom_range(0, 1000);
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] addr, input int hold, input logic col,
                         input logic [31:0] col_data, input string tag);
        logic [32:0] exp;
        int          lat;
        wait_ready(tag);
        exp       = ref_fetch(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b0;
        if (col) begin
            wr_en   = 1'b1;
            wr_addr = addr;
            wr_data = col_data;
        end
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        wr_en     = 1'b0;
        wr_addr   = $urandom;
        if (col) ref_write(addr, col_data);
        check({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        check({tag, "_data"}, rsp_data, exp[31:0]);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_hold_data"}, rsp_data, exp[31:0]);
            check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ref_cnt++;
        check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_done_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, "_done_data"}, rsp_data, exp[31:0]);
`ifdef IMEM_FETCH_CNT_EN
        check({tag, "_fetch_count"}, fetch_count, 32'(ref_cnt));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 32'd0;
        wr_data   = 32'd0;
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
`ifdef IMEM_FETCH_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
`endif

        // Preload while reset is held low.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       d = 32'h00000013;
                1:       d = 32'h00100093;
                2:       d = 32'h00200113;
                3:       d = 32'h00308193;
                default: d = $urandom;
            endcase
            wr_en   = 1'b1;
            wr_addr = BASE_ADDR + 32'(4 * i);
            wr_data = d;
            ref_write(wr_addr, d);
            tick();
        end
        wr_en = 1'b0;
        check("preload_ready_low", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        tick();
        check("release_ready", {31'd0, req_ready}, 32'd1);

        fetch(32'h4, 0, 1'b0, 32'd0, "basic");
        fetch(32'hC, 5, 1'b0, 32'd0, "backpressure");
        fetch(32'h6, 1, 1'b0, 32'd0, "misaligned");
        fetch(32'h400, 0, 1'b0, 32'd0, "out_of_range");
        fetch(32'hFFFFFFFC, 0, 1'b0, 32'd0, "top_addr");
        fetch(32'h8, 0, 1'b1, 32'hDEADBEEF, "collide_old");
        fetch(32'h8, 0, 1'b0, 32'd0, "collide_new");

        // Abort a transaction while it is waiting.
        wait_ready("abort");
        req_valid = 1'b1;
        req_addr  = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        ref_cnt = 0;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd0);
`ifdef IMEM_FETCH_CNT_EN
        check("abort_fetch_count", fetch_count, 32'd0);
`endif
        reset     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("abort_release_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rsp_ready = 1'b0;
        fetch(32'h0, 0, 1'b0, 32'd0, "after_abort");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = gen_addr();
                if (legal(a) && a < BASE_ADDR + 64) a = a + 64;
                d       = $urandom;
                wr_en   = 1'b1;
                wr_addr = a;
                wr_data = d;
                tick();
                wr_en = 1'b0;
                ref_write(a, d);
            end
            a = gen_addr();
            fetch(a, $urandom_range(0, 3), 1'b0, 32'd0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
